// File: rtl/matmul_pkg.sv
// Shared constants and state type for the 4x4 matrix-multiply job controller.
package matmul_pkg;

    localparam int ELEM_W     = 8;
    localparam int ELEMS      = 4;
    localparam int MAT_DIM    = 4;
    localparam int BEAT_W     = ELEMS * ELEM_W;
    localparam int LOAD_BEATS = 2 * MAT_DIM * MAT_DIM / ELEMS;
    localparam int BEAT_CNT_W = $clog2(LOAD_BEATS);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        LOAD,
        WAIT,
        RD_REQ,
        RD_CAP,
        RD_OUT
    } ctrl_state_t;

endpackage

// File: rtl/stall_timer.sv
// 8-bit consecutive-stall counter; terminal fires on the TIMEOUT-th enabled cycle.
module stall_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign terminal = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/matmul_job_ctrl.sv
// Job sequencer for the 4x4 matrix-multiply engine: load pass-through, compute wait,
// column drain with output backpressure, engine reset between jobs, stall timeout.
module matmul_job_ctrl
    import matmul_pkg::*;
#(
    parameter int WIDTH        = ELEM_W,
    parameter int NUM_ELEMENTS = ELEMS,
    parameter int MATRIX_WIDTH = MAT_DIM,
    parameter int COMPUTE_WAIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                            w_clk,
    input  logic                            w_reset_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_ELEMENTS*WIDTH-1:0]   s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_ELEMENTS*WIDTH-1:0]   m_data,
    output logic                            m_last,
    output logic [NUM_ELEMENTS*WIDTH-1:0]   eng_wdata,
    output logic                            eng_w_en,
    input  logic                            eng_w_ready,
    output logic                            eng_r_en,
    input  logic [NUM_ELEMENTS*WIDTH-1:0]   eng_Res,
    input  logic                            eng_r_ready,
    output logic                            eng_reset,
    output logic                            busy,
    output logic                            job_done,
    output logic                            timeout_err,
    output logic [7:0]                      job_cnt
);

    localparam int BEATS  = 2 * MATRIX_WIDTH * MATRIX_WIDTH / NUM_ELEMENTS;
    localparam int WAIT_W = $clog2(COMPUTE_WAIT + 1);
    localparam int COL_W  = $clog2(MATRIX_WIDTH);

    ctrl_state_t state, next_state;

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [COL_W-1:0]      col;
    logic                  stall;
    logic                  timeout;
    logic                  last_beat;
    logic                  wait_done;
    logic                  last_col;

    assign last_beat = (beat_cnt == BEAT_CNT_W'(BEATS - 1));
    assign wait_done = (wait_cnt == WAIT_W'(COMPUTE_WAIT - 1));
    assign last_col  = (col == COL_W'(MATRIX_WIDTH - 1));
    assign eng_wdata = s_data;
    assign busy      = (state != IDLE);

    // A host with nothing to send is not a stall; only the engine withholding ready is.
    assign stall = ((state == LOAD)   && !eng_w_ready) ||
                   ((state == RD_CAP) && !eng_r_ready);

    stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk      (w_clk),
        .reset_n  (w_reset_n),
        .clear    (!stall),
        .enable   (stall),
        .terminal (timeout)
    );

    always_ff @(posedge w_clk) begin
        if (!w_reset_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        eng_w_en   = 1'b0;
        eng_r_en   = 1'b0;
        eng_reset  = 1'b0;
        case (state)
            CLEAR: begin
                eng_reset  = 1'b1;
                next_state = IDLE;
            end
            IDLE, LOAD: begin
                s_ready  = eng_w_ready;
                eng_w_en = s_valid & s_ready;
                if (eng_w_en) begin
                    next_state = last_beat ? WAIT : LOAD;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    next_state = RD_REQ;
                end
            end
            RD_REQ: begin
                eng_r_en   = 1'b1;
                next_state = RD_CAP;
            end
            RD_CAP: begin
                if (eng_r_ready) begin
                    next_state = RD_OUT;
                end else begin
                    eng_r_en = 1'b1;
                end
            end
            RD_OUT: begin
                if (m_ready) begin
                    next_state = last_col ? CLEAR : RD_REQ;
                end
            end
            default: next_state = CLEAR;
        endcase
        if (timeout) begin
            next_state = CLEAR;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_reset_n) begin
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            col         <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            job_done    <= 1'b0;
            timeout_err <= 1'b0;
            job_cnt     <= '0;
        end else begin
            job_done <= 1'b0;
            if (eng_w_en) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_CNT_W'(1);
            end
            if (state == WAIT) begin
                wait_cnt <= wait_done ? '0 : wait_cnt + WAIT_W'(1);
                col      <= '0;
            end
            if ((state == RD_CAP) && eng_r_ready) begin
                m_data  <= eng_Res;
                m_valid <= 1'b1;
                m_last  <= last_col;
            end
            if ((state == RD_OUT) && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                col     <= col + COL_W'(1);
                if (last_col) begin
                    job_cnt  <= job_cnt + 8'd1;
                    job_done <= 1'b1;
                end
            end
            // Abort: partial load is discarded so the next job starts at beat 0.
            if (timeout) begin
                timeout_err <= 1'b1;
                job_done    <= 1'b1;
                m_valid     <= 1'b0;
                m_last      <= 1'b0;
                beat_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_matmul_job_ctrl.sv
// Directed bench for matmul_job_ctrl: identity job, backpressure, timeouts, reset, count wrap.
module tb_matmul_job_ctrl;

    logic        w_clk = 1'b0;
    logic        w_reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [31:0] eng_wdata;
    logic        eng_w_en;
    logic        eng_w_ready;
    logic        eng_r_en;
    logic [31:0] eng_Res;
    logic        eng_r_ready;
    logic        eng_reset;
    logic        busy;
    logic        job_done;
    logic        timeout_err;
    logic [7:0]  job_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] ident_col [4];

    always #5 w_clk = ~w_clk;

    matmul_job_ctrl dut (
        .w_clk       (w_clk),
        .w_reset_n   (w_reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .eng_wdata   (eng_wdata),
        .eng_w_en    (eng_w_en),
        .eng_w_ready (eng_w_ready),
        .eng_r_en    (eng_r_en),
        .eng_Res     (eng_Res),
        .eng_r_ready (eng_r_ready),
        .eng_reset   (eng_reset),
        .busy        (busy),
        .job_done    (job_done),
        .timeout_err (timeout_err),
        .job_cnt     (job_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Beat k covers rows r,r+1 (r = 0 or 2) of column k%4; A = I, B[r][c] = 4r+c+1.
    function automatic logic [31:0] ident_beat(input int k);
        int r;
        int c;
        logic [7:0] a0, a1, b0, b1;
        r  = 2 * (k / 4);
        c  = k % 4;
        a0 = (r == c) ? 8'd1 : 8'd0;
        a1 = ((r + 1) == c) ? 8'd1 : 8'd0;
        b0 = 8'(4 * r + c + 1);
        b1 = 8'(4 * (r + 1) + c + 1);
        return {a0, a1, b0, b1};
    endfunction

    task automatic load_beats(input int first, input int count, input bit ident);
        for (int k = first; k < first + count; k++) begin
            s_valid = 1'b1;
            s_data  = ident ? ident_beat(k) : 32'h01010202;
            #1;
            chk("load_s_ready", 32'(s_ready), 1);
            chk("load_w_en", 32'(eng_w_en), 1);
            chk("load_wdata", eng_wdata, s_data);
            tick();
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_to_rdreq();
        for (int i = 0; i < 4; i++) begin
            chk("wait_r_en", 32'(eng_r_en), 0);
            chk("wait_busy", 32'(busy), 1);
            tick();
        end
        chk("rdreq_r_en", 32'(eng_r_en), 1);
    endtask

    task automatic drain_col(input int c, input logic [31:0] res, input int hold);
        eng_Res     = res;
        eng_r_ready = 1'b1;
        m_ready     = (hold == 0);
        #1;
        chk("req_r_en", 32'(eng_r_en), 1);
        chk("req_m_valid", 32'(m_valid), 0);
        tick();
        chk("cap_r_en", 32'(eng_r_en), 0);
        chk("cap_m_valid", 32'(m_valid), 0);
        tick();
        chk("out_m_valid", 32'(m_valid), 1);
        chk("out_m_data", m_data, res);
        chk("out_m_last", 32'(m_last), 32'(c == 3));
        chk("out_job_done", 32'(job_done), 0);
        for (int i = 0; i < hold; i++) begin
            eng_Res = 32'hDEADBEEF;
            tick();
            chk("hold_m_valid", 32'(m_valid), 1);
            chk("hold_m_data", m_data, res);
            chk("hold_r_en", 32'(eng_r_en), 0);
        end
        m_ready = 1'b1;
        #1;
        tick();
    endtask

    initial begin
        ident_col[0] = 32'h0105090D;
        ident_col[1] = 32'h02060A0E;
        ident_col[2] = 32'h03070B0F;
        ident_col[3] = 32'h04080C10;

        w_reset_n   = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;
        eng_w_ready = 1'b1;
        eng_Res     = '0;
        eng_r_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_eng_reset", 32'(eng_reset), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_r_en", 32'(eng_r_en), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_job_done", 32'(job_done), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_job_cnt", 32'(job_cnt), 0);
        chk("rst_s_ready", 32'(s_ready), 0);

        w_reset_n = 1'b1;
        #1;
        chk("rel_eng_reset", 32'(eng_reset), 1);
        chk("rel_s_ready", 32'(s_ready), 0);
        tick();
        chk("idle_eng_reset", 32'(eng_reset), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_s_ready", 32'(s_ready), 1);

        // Identity job with backpressure on the second result beat
        load_beats(0, 8, 1'b1);
        wait_to_rdreq();
        for (int c = 0; c < 4; c++) begin
            drain_col(c, ident_col[c], (c == 1) ? 9 : 0);
        end
        chk("id_job_done", 32'(job_done), 1);
        chk("id_job_cnt", 32'(job_cnt), 1);
        chk("id_eng_reset", 32'(eng_reset), 1);
        chk("id_m_valid", 32'(m_valid), 0);
        chk("id_clear_s_ready", 32'(s_ready), 0);
        tick();
        chk("id_done_once", 32'(job_done), 0);
        chk("id_idle_busy", 32'(busy), 0);

        // Host idle in LOAD is not a stall; then engine write stall after beat 3
        load_beats(0, 1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        chk("hostidle_timeout", 32'(timeout_err), 0);
        chk("hostidle_eng_reset", 32'(eng_reset), 0);
        chk("hostidle_busy", 32'(busy), 1);
        load_beats(1, 2, 1'b1);
        eng_w_ready = 1'b0;
        s_valid     = 1'b1;
        s_data      = ident_beat(3);
        #1;
        chk("wstall_s_ready", 32'(s_ready), 0);
        chk("wstall_w_en", 32'(eng_w_en), 0);
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        chk("wstall_pre_timeout", 32'(timeout_err), 0);
        chk("wstall_pre_eng_reset", 32'(eng_reset), 0);
        tick();
        chk("wstall_timeout", 32'(timeout_err), 1);
        chk("wstall_job_done", 32'(job_done), 1);
        chk("wstall_eng_reset", 32'(eng_reset), 1);
        chk("wstall_job_cnt", 32'(job_cnt), 1);
        s_valid     = 1'b0;
        eng_w_ready = 1'b1;
        tick();
        chk("wstall_done_once", 32'(job_done), 0);
        chk("wstall_sticky", 32'(timeout_err), 1);
        chk("wstall_idle", 32'(busy), 0);

        // Reset during RD_OUT of column 1
        load_beats(0, 8, 1'b1);
        wait_to_rdreq();
        drain_col(0, ident_col[0], 0);
        m_ready = 1'b0;
        eng_Res = ident_col[1];
        tick();
        tick();
        chk("midrst_m_valid_pre", 32'(m_valid), 1);
        w_reset_n = 1'b0;
        tick();
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_eng_reset", 32'(eng_reset), 1);
        chk("midrst_job_cnt", 32'(job_cnt), 0);
        chk("midrst_timeout", 32'(timeout_err), 0);
        chk("midrst_job_done", 32'(job_done), 0);
        w_reset_n = 1'b1;
        m_ready   = 1'b1;
        tick();
        chk("midrst_idle", 32'(busy), 0);
        chk("midrst_no_done", 32'(job_done), 0);

        // Engine read stall: r_en repeats, abort after 255 cycles
        load_beats(0, 8, 1'b1);
        wait_to_rdreq();
        eng_r_ready = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 254; i++) begin
            chk("rstall_r_en", 32'(eng_r_en), 1);
            tick();
        end
        chk("rstall_r_en_last", 32'(eng_r_en), 1);
        chk("rstall_pre_timeout", 32'(timeout_err), 0);
        tick();
        chk("rstall_timeout", 32'(timeout_err), 1);
        chk("rstall_job_done", 32'(job_done), 1);
        chk("rstall_job_cnt", 32'(job_cnt), 0);
        chk("rstall_m_valid", 32'(m_valid), 0);
        chk("rstall_r_en_off", 32'(eng_r_en), 0);
        chk("rstall_eng_reset", 32'(eng_reset), 1);
        eng_r_ready = 1'b1;
        tick();

        // 256 jobs of all-ones times all-twos; count wraps to zero
        for (int j = 0; j < 256; j++) begin
            load_beats(0, 8, 1'b0);
            wait_to_rdreq();
            for (int c = 0; c < 4; c++) begin
                drain_col(c, 32'h08080808, 0);
            end
            chk("wrap_job_done", 32'(job_done), 1);
            chk("wrap_job_cnt", 32'(job_cnt), (j + 1) % 256);
            tick();
        end
        chk("wrap_final_cnt", 32'(job_cnt), 0);
        chk("wrap_final_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
